// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : control_pkg
//  Brief    : Shared types and encodings for the registered RV32 control pipe
//  Revision : 1.0  initial release
// ============================================================================
package control_pkg;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_XOR   = 4'b0010,
        ALU_ADD   = 4'b0011,
        ALU_SUB   = 4'b0100,
        ALU_MUL   = 4'b0101,
        ALU_MULH  = 4'b0110,
        ALU_MULHU = 4'b0111,
        ALU_SLL   = 4'b1000,
        ALU_SRL   = 4'b1001,
        ALU_SRA   = 4'b1010,
        ALU_SLT   = 4'b1100,
        ALU_SLTU  = 4'b1101
    } aluop_e;

    typedef enum logic [1:0] {
        REG_CSR = 2'b00,
        REG_LUI = 2'b01,
        REG_ALU = 2'b10,
        REG_PC4 = 2'b11
    } regsel_e;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } state_e;

    localparam int         GPIO_MAX      = 8;

    localparam logic [6:0] OP_R          = 7'h33;
    localparam logic [6:0] OP_I          = 7'h13;
    localparam logic [6:0] OP_LUI        = 7'h37;
    localparam logic [6:0] OP_JAL        = 7'h6F;
    localparam logic [6:0] OP_JALR       = 7'h67;
    localparam logic [6:0] OP_BRANCH     = 7'h63;
    localparam logic [6:0] OP_SYSTEM     = 7'h73;

    localparam logic [6:0] F7_BASE       = 7'h00;
    localparam logic [6:0] F7_ALT        = 7'h20;
    localparam logic [6:0] F7_MULDIV     = 7'h01;
    localparam logic [2:0] F3_CSRRW      = 3'b001;

    localparam logic [11:0] CSR_SW        = 12'hF00;
    localparam logic [11:0] CSR_GPIO_BASE = 12'hF02;

    // EX-stage control bundle; gpio_we is sized for the largest channel count
    typedef struct packed {
        logic                valid;
        aluop_e              aluop;
        logic                alusrc;
        regsel_e             regsel;
        logic                regwrite;
        logic [GPIO_MAX-1:0] gpio_we;
        logic                illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        valid:    1'b0,
        aluop:    ALU_ADD,
        alusrc:   1'b1,
        regsel:   REG_ALU,
        regwrite: 1'b0,
        gpio_we:  '0,
        illegal:  1'b0
    };

endpackage
`default_nettype wire

// File: rtl/control_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : control_pipe_if
//  Brief    : Decode-side instruction feed and EX-stage control outputs
//  Revision : 1.0  initial release
// ============================================================================
interface control_pipe_if #(
    parameter int NUM_GPIO = 2
);
    logic                instr_valid;
    logic [31:0]         instr;
    logic                flush;
    logic                stall_F;
    logic                ex_valid;
    logic [3:0]          aluop;
    logic                alusrc;
    logic [1:0]          regsel;
    logic                regwrite;
    logic [NUM_GPIO-1:0] gpio_we;
    logic                illegal;

    modport master (
        output instr_valid, instr, flush,
        input  stall_F, ex_valid, aluop, alusrc, regsel, regwrite, gpio_we, illegal
    );

    modport slave (
        input  instr_valid, instr, flush,
        output stall_F, ex_valid, aluop, alusrc, regsel, regwrite, gpio_we, illegal
    );
endinterface
`default_nettype wire

// File: rtl/control_pipe_decode.sv
`default_nettype none
// ============================================================================
//  Module   : control_decode
//  Brief    : Combinational RV32 instruction -> EX control bundle decoder
//  Revision : 1.0  initial release
// ============================================================================
module control_decode
    import control_pkg::*;
#(
    parameter int NUM_GPIO = 2
) (
    input  wire logic [31:0] instr,
    output ctrl_t            ctrl,
    output logic             is_mul,
    output logic             illegal
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [11:0] w_csr;
    logic        w_legal;
    logic        w_unused_fields;

    assign w_opcode        = instr[6:0];
    assign w_funct3        = instr[14:12];
    assign w_funct7        = instr[31:25];
    assign w_csr           = instr[31:20];
    assign w_unused_fields = ^{instr[19:15], instr[11:7]};
    assign illegal         = ctrl.illegal;

    // Decode opcode/funct fields; anything not recognised collapses to the illegal bundle
    always_comb begin
        ctrl       = CTRL_BUBBLE;
        ctrl.valid = 1'b1;
        is_mul     = 1'b0;
        w_legal    = 1'b0;
        case (w_opcode)
            OP_R: begin
                ctrl.alusrc   = 1'b0;
                ctrl.regwrite = 1'b1;
                w_legal       = 1'b1;
                case ({w_funct7, w_funct3})
                    {F7_BASE,   3'b000}: ctrl.aluop = ALU_ADD;
                    {F7_ALT,    3'b000}: ctrl.aluop = ALU_SUB;
                    {F7_BASE,   3'b001}: ctrl.aluop = ALU_SLL;
                    {F7_BASE,   3'b010}: ctrl.aluop = ALU_SLT;
                    {F7_BASE,   3'b011}: ctrl.aluop = ALU_SLTU;
                    {F7_BASE,   3'b100}: ctrl.aluop = ALU_XOR;
                    {F7_BASE,   3'b101}: ctrl.aluop = ALU_SRL;
                    {F7_ALT,    3'b101}: ctrl.aluop = ALU_SRA;
                    {F7_BASE,   3'b110}: ctrl.aluop = ALU_OR;
                    {F7_BASE,   3'b111}: ctrl.aluop = ALU_AND;
                    {F7_MULDIV, 3'b000}: begin ctrl.aluop = ALU_MUL;   is_mul = 1'b1; end
                    {F7_MULDIV, 3'b001}: begin ctrl.aluop = ALU_MULH;  is_mul = 1'b1; end
                    {F7_MULDIV, 3'b011}: begin ctrl.aluop = ALU_MULHU; is_mul = 1'b1; end
                    default:             w_legal = 1'b0;
                endcase
            end
            OP_I: begin
                ctrl.regwrite = 1'b1;
                w_legal       = 1'b1;
                case (w_funct3)
                    3'b000:  ctrl.aluop = ALU_ADD;
                    3'b111:  ctrl.aluop = ALU_AND;
                    3'b110:  ctrl.aluop = ALU_OR;
                    3'b100:  ctrl.aluop = ALU_XOR;
                    3'b001: begin
                        if (w_funct7 == F7_BASE) ctrl.aluop = ALU_SLL;
                        else                     w_legal    = 1'b0;
                    end
                    3'b101: begin
                        if (w_funct7 == F7_BASE)     ctrl.aluop = ALU_SRL;
                        else if (w_funct7 == F7_ALT) ctrl.aluop = ALU_SRA;
                        else                         w_legal    = 1'b0;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            OP_LUI: begin
                ctrl.regsel   = REG_LUI;
                ctrl.regwrite = 1'b1;
                w_legal       = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                ctrl.regsel   = REG_PC4;
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALU_SRA;
                w_legal       = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.alusrc = 1'b0;
                w_legal     = 1'b1;
                case (w_funct3)
                    3'b000, 3'b001: ctrl.aluop = ALU_SUB;
                    3'b100, 3'b101: ctrl.aluop = ALU_SLT;
                    3'b110, 3'b111: ctrl.aluop = ALU_SLTU;
                    default:        w_legal    = 1'b0;
                endcase
            end
            OP_SYSTEM: begin
                if (w_funct3 == F3_CSRRW) begin
                    if (w_csr == CSR_SW) begin
                        ctrl.regsel   = REG_CSR;
                        ctrl.regwrite = 1'b1;
                        w_legal       = 1'b1;
                    end
                    for (int k = 0; k < NUM_GPIO; k++) begin
                        if (w_csr == CSR_GPIO_BASE + 12'(k)) begin
                            ctrl.gpio_we[k] = 1'b1;
                            w_legal         = 1'b1;
                        end
                    end
                end
            end
            default: w_legal = 1'b0;
        endcase
        if (!w_legal) begin
            ctrl         = CTRL_BUBBLE;
            ctrl.valid   = 1'b1;
            ctrl.illegal = 1'b1;
            is_mul       = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/control_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : control_pipe
//  Brief    : Registered EX-stage control with multiply wait FSM and flush
//  Revision : 1.0  initial release
// ============================================================================
module control_pipe
    import control_pkg::*;
#(
    parameter int MUL_LAT  = 3,
    parameter int NUM_GPIO = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    control_pipe_if.slave bus
);

    localparam int              CNT_W    = $clog2(MUL_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt,   w_cnt_n;
    ctrl_t            r_ctrl,  w_ctrl_n;
    ctrl_t            w_dec;
    logic             w_is_mul;
    logic             w_dec_illegal;
    logic             w_unused_dec;

    assign w_unused_dec = w_dec_illegal;

    control_decode #(
        .NUM_GPIO (NUM_GPIO)
    ) u_decode (
        .instr   (bus.instr),
        .ctrl    (w_dec),
        .is_mul  (w_is_mul),
        .illegal (w_dec_illegal)
    );

    // State, countdown and EX control register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_ctrl  <= CTRL_BUBBLE;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_ctrl  <= w_ctrl_n;
        end
    end

    // Next state: accept/bubble in RUN, hold and count down while a multiply occupies EX
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_ctrl_n  = r_ctrl;
        case (r_state)
            RUN: begin
                if (bus.flush || !bus.instr_valid) begin
                    w_ctrl_n = CTRL_BUBBLE;
                end else begin
                    w_ctrl_n = w_dec;
                    if (w_is_mul && (MUL_LAT > 1)) begin
                        w_ctrl_n.regwrite = 1'b0;
                        w_cnt_n           = CNT_LOAD;
                        w_state_n         = MUL_WAIT;
                    end
                end
            end
            MUL_WAIT: begin
                if (bus.flush) begin
                    w_ctrl_n  = CTRL_BUBBLE;
                    w_cnt_n   = '0;
                    w_state_n = RUN;
                end else begin
                    if (r_cnt == CNT_ONE) begin
                        w_ctrl_n.regwrite = 1'b1;
                        w_state_n         = RUN;
                    end
                    if (r_cnt != '0) begin
                        w_cnt_n = r_cnt - CNT_ONE;
                    end
                end
            end
            default: begin
                w_ctrl_n  = CTRL_BUBBLE;
                w_cnt_n   = '0;
                w_state_n = RUN;
            end
        endcase
    end

    assign bus.stall_F  = (r_state == MUL_WAIT);
    assign bus.ex_valid = r_ctrl.valid;
    assign bus.aluop    = r_ctrl.aluop;
    assign bus.alusrc   = r_ctrl.alusrc;
    assign bus.regsel   = r_ctrl.regsel;
    assign bus.regwrite = r_ctrl.regwrite;
    assign bus.gpio_we  = r_ctrl.gpio_we[NUM_GPIO-1:0];
    assign bus.illegal  = r_ctrl.illegal;

    if (NUM_GPIO < GPIO_MAX) begin : g_unused_gpio
        logic w_unused_gpio;
        assign w_unused_gpio = ^r_ctrl.gpio_we[GPIO_MAX-1:NUM_GPIO];
    end

endmodule
`default_nettype wire
